// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the 2048 input path.
//   DIR_*            2-bit move direction codes driven to game_logic
//   sched_state_e    move_scheduler FSM states
//   onehot_to_dir()  maps a one-hot {left,down,right,up} vector to a DIR_* code
// -----------------------------------------------------------------------------
package game_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_e;

    // Callers only pass one-hot vectors; the priority chain just keeps the
    // function total.
    function automatic logic [1:0] onehot_to_dir(input logic [3:0] oh);
        if (oh[3])      return DIR_LEFT;
        else if (oh[2]) return DIR_DOWN;
        else if (oh[1]) return DIR_RIGHT;
        else            return DIR_UP;
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// -----------------------------------------------------------------------------
// move_scheduler_if
// Valid/ready move handshake between move_scheduler and game_logic.
//   move_valid  move presented
//   move_dir    direction code (game_pkg encoding)
//   move_ready  consumer accepts the move
// master = move_scheduler side, slave = game_logic side.
// -----------------------------------------------------------------------------
interface move_scheduler_if;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;

    modport master (output move_valid, output move_dir, input move_ready);
    modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/move_fifo.sv
// -----------------------------------------------------------------------------
// move_fifo
// DEPTH x 2-bit synchronous FIFO of pending moves.
//   clk, rst_n   clock, synchronous active-low reset
//   push/push_dir  write an entry (caller guarantees room, or a same-cycle pop)
//   pop          remove the head entry
//   flush        discard all entries; a same-cycle push becomes the only entry
//   head_dir     current head entry
//   count        entries held
//   full         count == DEPTH
// -----------------------------------------------------------------------------
module move_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [1:0]               push_dir,
    input  logic                     pop,
    input  logic                     flush,
    output logic [1:0]               head_dir,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // NOTE: the storage array carries no reset; count and pointers decide
    // which entries are meaningful, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[flush ? '0 : wr_ptr] <= push_dir;
        end
    end

    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dir = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
// Merges button, gamepad and debug move requests into one paced move stream.
//   clk, rst_n          clock, synchronous active-low reset
//   vsync_rising_edge   one-cycle pulse per frame (paces WAIT)
//   enable              game active; gates btn/pad, falling edge flushes queue
//   btn_dir/pad_dir/dbg_dir  level requests {left,down,right,up}
//   mv (master)         move_valid/move_dir out, move_ready in
//   queue_count         entries buffered
//   drop_pulse          one-cycle pulse when any request is discarded
//   busy                FSM not IDLE or queue not empty
// -----------------------------------------------------------------------------
module move_scheduler
    import game_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int FRAME_GAP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vsync_rising_edge,
    input  logic                     enable,
    input  logic [3:0]               btn_dir,
    input  logic [3:0]               pad_dir,
    input  logic [3:0]               dbg_dir,
    move_scheduler_if.master         mv,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     drop_pulse,
    output logic                     busy
);
    localparam int GW = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;

    logic [3:0]   btn_prev, pad_prev, dbg_prev;
    logic         en_q;
    logic [3:0]   btn_rise, pad_rise, dbg_rise;
    logic         btn_ok, pad_ok, dbg_ok;
    logic         any_multi;
    logic         sel_valid, others_valid;
    logic [1:0]   sel_dir;
    logic         flush, pop, push, fifo_full;
    logic [1:0]   head_dir;
    logic [GW-1:0] gap_cnt;
    sched_state_e state;

    assign dbg_rise = dbg_dir & ~dbg_prev;
    assign btn_rise = btn_dir & ~btn_prev & {4{enable}};
    assign pad_rise = pad_dir & ~pad_prev & {4{enable}};

    assign dbg_ok = $onehot(dbg_rise);
    assign btn_ok = $onehot(btn_rise);
    assign pad_ok = $onehot(pad_rise);

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign any_multi = ((dbg_rise & (dbg_rise - 4'd1)) != 4'd0) ||
                       ((btn_rise & (btn_rise - 4'd1)) != 4'd0) ||
                       ((pad_rise & (pad_rise - 4'd1)) != 4'd0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        sel_valid    = 1'b0;
        sel_dir      = DIR_UP;
        others_valid = 1'b0;
        if (dbg_ok) begin
            sel_valid    = 1'b1;
            sel_dir      = onehot_to_dir(dbg_rise);
            others_valid = btn_ok | pad_ok;
        end else if (btn_ok) begin
            sel_valid    = 1'b1;
            sel_dir      = onehot_to_dir(btn_rise);
            others_valid = pad_ok;
        end else if (pad_ok) begin
            sel_valid    = 1'b1;
            sel_dir      = onehot_to_dir(pad_rise);
        end
    end

    // A flush empties the queue, so it also frees room for a same-cycle push;
    // the head is not popped on a flush cycle since it is being discarded.
    assign flush = en_q & ~enable;
    assign pop   = (state == IDLE) && (queue_count != '0) && !flush;
    assign push  = sel_valid && (!fifo_full || pop || flush);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev   <= 4'b1111;
            pad_prev   <= 4'b1111;
            dbg_prev   <= 4'b1111;
            en_q       <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            btn_prev   <= btn_dir;
            pad_prev   <= pad_dir;
            dbg_prev   <= dbg_dir;
            en_q       <= enable;
            drop_pulse <= any_multi | others_valid | (sel_valid & ~push);
        end
    end

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dir (sel_dir),
        .pop      (pop),
        .flush    (flush),
        .head_dir (head_dir),
        .count    (queue_count),
        .full     (fifo_full)
    );

    // ISSUE spends one cycle loading move_dir before raising move_valid, so
    // the popped direction is already stable when it is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            mv.move_valid <= 1'b0;
            mv.move_dir   <= DIR_UP;
            gap_cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        mv.move_dir <= head_dir;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!mv.move_valid) begin
                        mv.move_valid <= 1'b1;
                    end else if (mv.move_ready) begin
                        mv.move_valid <= 1'b0;
                        if (FRAME_GAP > 0) begin
                            gap_cnt <= GW'(FRAME_GAP);
                            state   <= WAIT;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (vsync_rising_edge) begin
                        gap_cnt <= gap_cnt - GW'(1);
                        if (gap_cnt == GW'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || (queue_count != '0);

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
// Drives move_scheduler with directed scenarios then random traffic, and
// checks every cycle against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_move_scheduler;
    import game_pkg::*;

    localparam int DEPTH     = 4;
    localparam int FRAME_GAP = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync_rising_edge;
    logic       enable;
    logic [3:0] btn_dir, pad_dir, dbg_dir;
    logic [$clog2(DEPTH):0] queue_count;
    logic       drop_pulse;
    logic       busy;

    move_scheduler_if mv_if ();

    move_scheduler #(.DEPTH(DEPTH), .FRAME_GAP(FRAME_GAP)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .vsync_rising_edge (vsync_rising_edge),
        .enable            (enable),
        .btn_dir           (btn_dir),
        .pad_dir           (pad_dir),
        .dbg_dir           (dbg_dir),
        .mv                (mv_if),
        .queue_count       (queue_count),
        .drop_pulse        (drop_pulse),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_prev [3];
    logic       m_en_q;
    logic [1:0] m_q [$];
    bit         m_pending;   // popped, not yet presented
    bit         m_valid;
    logic [1:0] m_dir;
    int         m_gap;       // frames still to wait before the next issue
    bit         m_drop;

    task automatic model_reset();
        for (int s = 0; s < 3; s++) m_prev[s] = 4'b1111;
        m_en_q = 1'b0;
        m_q.delete();
        m_pending = 1'b0;
        m_valid = 1'b0;
        m_dir = 2'd0;
        m_gap = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] cur [3];
        logic [3:0] rise;
        bit have, multi, extra, hs, idle, flush, pop, accept;
        logic [1:0] sel;
        int ones;
        cur[0] = dbg_dir; cur[1] = btn_dir; cur[2] = pad_dir;
        have = 0; multi = 0; extra = 0; sel = 2'd0;
        for (int s = 0; s < 3; s++) begin   // index order = priority
            rise = cur[s] & ~m_prev[s];
            if (s != 0 && !enable) rise = 4'b0000;
            ones = $countones(rise);
            if (ones > 1) multi = 1;
            else if (ones == 1) begin
                if (have) extra = 1;
                else begin
                    have = 1;
                    for (int b = 0; b < 4; b++) if (rise[b]) sel = 2'(b);
                end
            end
            m_prev[s] = cur[s];
        end
        hs     = m_valid && mv_if.move_ready;
        idle   = !m_pending && !m_valid && (m_gap == 0);
        flush  = m_en_q && !enable;
        pop    = idle && (m_q.size() > 0) && !flush;
        accept = have && ((m_q.size() < DEPTH) || pop || flush);
        m_drop = multi || extra || (have && !accept);

        if (m_gap > 0 && vsync_rising_edge) m_gap--;
        if (hs) begin m_valid = 0; m_gap = FRAME_GAP; end
        if (m_pending) begin m_valid = 1; m_pending = 0; end
        if (pop) begin m_dir = m_q.pop_front(); m_pending = 1; end
        if (flush) m_q.delete();
        if (accept) m_q.push_back(sel);
        m_en_q = enable;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("move_valid",  32'(mv_if.move_valid), 32'(m_valid));
            check("move_dir",    32'(mv_if.move_dir),   32'(m_dir));
            check("queue_count", 32'(queue_count),      32'(m_q.size()));
            check("drop_pulse",  32'(drop_pulse),       32'(m_drop));
            check("busy",        32'(busy),
                  32'(m_pending || m_valid || m_gap > 0 || m_q.size() > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        vsync_rising_edge = 1'b1;
        tick();
        vsync_rising_edge = 1'b0;
    endtask

    function automatic logic [3:0] rand_req(input logic [3:0] cur);
        int r;
        if ($urandom_range(0, 9) < 7) return cur;
        r = $urandom_range(0, 19);
        if (r < 10) return 4'b0000;
        if (r < 17) return 4'b0001 << $urandom_range(0, 3);
        return 4'($urandom);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; vsync_rising_edge = 1'b0; enable = 1'b1;
        btn_dir = 4'b0001; pad_dir = 4'b0000; dbg_dir = 4'b0000;
        mv_if.move_ready = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick(2);
        check("reset_valid", 32'(mv_if.move_valid), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(3);
        check("held_btn_no_enqueue", 32'(queue_count), 32'd0);
        check("held_btn_no_valid",   32'(mv_if.move_valid), 32'd0);

        // Press up: presented two edges after the sampling edge.
        btn_dir = 4'b0000; tick();
        btn_dir = 4'b0001; tick(2);
        check("latency_not_yet", 32'(mv_if.move_valid), 32'd0);
        tick();
        check("latency_valid", 32'(mv_if.move_valid), 32'd1);
        check("latency_dir",   32'(mv_if.move_dir), 32'(DIR_UP));
        tick(10);
        check("stall_dir_stable", 32'(mv_if.move_dir), 32'(DIR_UP));
        mv_if.move_ready = 1'b1; tick();
        check("handshake_clears", 32'(mv_if.move_valid), 32'd0);
        mv_if.move_ready = 1'b0; btn_dir = 4'b0000;
        pulse_vsync();

        // Three sources rise together: dbg wins, one drop pulse.
        dbg_dir = 4'b0010; btn_dir = 4'b0001; pad_dir = 4'b1000;
        tick();
        check("arb_drop",  32'(drop_pulse), 32'd1);
        check("arb_count", 32'(queue_count), 32'd1);
        tick();
        check("arb_drop_one_cycle", 32'(drop_pulse), 32'd0);
        tick();
        check("arb_dir", 32'(mv_if.move_dir), 32'(DIR_RIGHT));
        mv_if.move_ready = 1'b1; tick();
        mv_if.move_ready = 1'b0;
        dbg_dir = 4'b0000; btn_dir = 4'b0000; pad_dir = 4'b0000;
        pulse_vsync();

        // Frame gap: the second move waits for a vsync after the first handshake.
        mv_if.move_ready = 1'b1;
        btn_dir = 4'b1000; tick();
        btn_dir = 4'b0000; tick(2);
        check("gap_first_valid", 32'(mv_if.move_valid), 32'd1);
        tick(2);
        btn_dir = 4'b0100; tick();
        for (int i = 0; i < 6; i++) begin
            check("gap_holdoff", 32'(mv_if.move_valid), 32'd0);
            tick();
        end
        btn_dir = 4'b0000;
        pulse_vsync();
        tick(2);
        check("gap_second_valid", 32'(mv_if.move_valid), 32'd1);
        check("gap_second_dir",   32'(mv_if.move_dir), 32'(DIR_DOWN));
        tick();
        mv_if.move_ready = 1'b0;

        // Fill while in WAIT, overflow, then push+pop on a full queue.
        for (int i = 0; i < 4; i++) begin
            btn_dir = 4'b0001 << i; tick();
            btn_dir = 4'b0000;      tick();
        end
        check("fill_count", 32'(queue_count), 32'd4);
        btn_dir = 4'b0001; tick();
        check("overflow_drop",  32'(drop_pulse), 32'd1);
        check("overflow_count", 32'(queue_count), 32'd4);
        btn_dir = 4'b0000;
        pulse_vsync();
        btn_dir = 4'b0010; tick();
        check("full_pushpop_count", 32'(queue_count), 32'd4);
        check("full_pushpop_nodrop", 32'(drop_pulse), 32'd0);
        tick();
        check("head_order", 32'(mv_if.move_dir), 32'(DIR_UP));

        // Enable falls while presenting: queue flushed, dbg push survives.
        btn_dir = 4'b0000; enable = 1'b0; dbg_dir = 4'b0100; tick();
        check("flush_keeps_dbg", 32'(queue_count), 32'd1);
        check("flush_keeps_valid", 32'(mv_if.move_valid), 32'd1);
        btn_dir = 4'b0001; tick();
        check("disabled_btn_ignored", 32'(queue_count), 32'd1);
        mv_if.move_ready = 1'b1; tick();
        check("flush_move_completes", 32'(mv_if.move_valid), 32'd0);
        mv_if.move_ready = 1'b0; btn_dir = 4'b0000; dbg_dir = 4'b0000; enable = 1'b1;

        // Reset while a move is presented.
        pulse_vsync();
        tick(2);
        check("pre_reset_valid", 32'(mv_if.move_valid), 32'd1);
        rst_n = 1'b0; tick();
        check("reset_mid_valid", 32'(mv_if.move_valid), 32'd0);
        check("reset_mid_count", 32'(queue_count), 32'd0);
        check("reset_mid_busy",  32'(busy), 32'd0);
        rst_n = 1'b1; tick();

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            btn_dir = rand_req(btn_dir);
            pad_dir = rand_req(pad_dir);
            dbg_dir = rand_req(dbg_dir);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            mv_if.move_ready  = ($urandom_range(0, 2) != 0);
            vsync_rising_edge = ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
